// File: rtl/kuuga_trace_pkg.sv
// Shared types and sizing helpers for the Gouram trace stream buffer.
// BEATS and BEAT_IDX_W describe the default 128-bit record; the functions size other widths.
package kuuga_trace_pkg;

    localparam int TRACE_W_DEF = 128;
    localparam int BEATS       = (TRACE_W_DEF + 31) / 32;
    localparam int BEAT_IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ts_state_t;

    function automatic int beats_of(input int w);
        return (w + 31) / 32;
    endfunction

    function automatic int beat_idx_w_of(input int b);
        return (b > 1) ? $clog2(b) : 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock circular FIFO with registered count and a combinational head read.
// Latency: one edge from push to visible at the head; a push while full or a pop while empty is ignored.
module trace_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o    = (count_q == (AW + 1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/trace_stream_buffer.sv
// Buffers Gouram trace records and streams them as 32-bit AXI-Stream beats, LSB word first, counting overflow drops.
// Latency: record on edge N is tvalid after N+1; tdata/tlast hold under tready=0, and a full FIFO drops new records.
module trace_stream_buffer
    import kuuga_trace_pkg::*;
#(
    parameter int TRACE_W = TRACE_W_DEF,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_valid_i,
    input  logic [TRACE_W-1:0]       trace_data_i,
    input  logic                     clear_i,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   fill_level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_count_o
);

    localparam int NBEATS = (TRACE_W == TRACE_W_DEF) ? BEATS : beats_of(TRACE_W);
    localparam int BIW    = (TRACE_W == TRACE_W_DEF) ? BEAT_IDX_W : beat_idx_w_of(NBEATS);
    localparam int SH_W   = NBEATS * 32;

    ts_state_t          state_q, state_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;
    logic [BIW-1:0]     beat_q, beat_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               fifo_full, fifo_empty, fifo_pop, fifo_push, drop;
    logic [TRACE_W-1:0] fifo_dat;
    logic [SH_W-1:0]    rec_ext;
    logic               last_beat;

    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign fifo_push = trace_valid_i && !fifo_full;
    assign drop      = trace_valid_i && fifo_full;

    trace_fifo #(
        .W     (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_dat_i (trace_data_i),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fill_level_o)
    );

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_i) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (clear_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        rec_ext                = '0;
        rec_ext[TRACE_W-1:0]   = fifo_dat;
    end

    assign last_beat = (beat_q == BIW'(NBEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
        end
    end

    // The last accepted beat reloads directly from the FIFO head so records run back to back.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        beat_d   = beat_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = rec_ext;
                    beat_d   = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (!last_beat) begin
                        shreg_d = shreg_q >> 32;
                        beat_d  = beat_q + 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = rec_ext;
                        beat_d   = '0;
                    end else begin
                        shreg_d  = '0;
                        beat_d   = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        m_axis_tvalid = (state_q == SEND);
        m_axis_tdata  = shreg_q[31:0];
        m_axis_tlast  = (state_q == SEND) && last_beat;
    end

    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_trace_stream_buffer.sv
// Randomised and directed bench for trace_stream_buffer with a beat scoreboard and an occupancy-level reference model.
module tb_trace_stream_buffer;

    localparam int TW    = 128;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int BEATS = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trace_valid_i = 1'b0;
    logic [TW-1:0]     trace_data_i = '0;
    logic              clear_i = 1'b0;
    logic              m_axis_tready = 1'b0;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [2:0]        fill_level_o;
    logic              overflow_o;
    logic [CNT_W-1:0]  drop_count_o;

    trace_stream_buffer #(
        .TRACE_W (TW),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trace_valid_i (trace_valid_i),
        .trace_data_i  (trace_data_i),
        .clear_i       (clear_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .fill_level_o  (fill_level_o),
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO occupancy, whether a record is in flight and how many of its beats remain.
    int          m_fifo  = 0;
    bit          m_busy  = 1'b0;
    int          m_left  = 0;
    bit          m_ovf   = 1'b0;
    int          m_drops = 0;
    logic [32:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [TW-1:0] d, input logic r, input logic c);
        int pre;
        bit accept;
        bit do_pop;
        pre    = m_fifo;
        accept = m_busy && r;
        do_pop = (pre > 0) && (!m_busy || (accept && m_left == 1));
        if (v && pre == DEPTH) begin
            m_ovf   = 1'b1;
            m_drops = c ? 1 : ((m_drops == MAXC) ? MAXC : m_drops + 1);
        end else if (c) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        if (do_pop) begin
            m_fifo--;
            m_busy = 1'b1;
            m_left = BEATS;
        end else if (accept) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
        if (v && pre < DEPTH) begin
            m_fifo++;
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back({(b == BEATS - 1) ? 1'b1 : 1'b0, d[b*32 +: 32]});
        end
    endtask

    task automatic cyc(input logic v, input logic [TW-1:0] d, input logic r, input logic c);
        trace_valid_i = v;
        trace_data_i  = d;
        m_axis_tready = r;
        clear_i       = c;
        @(posedge clk);
        model_edge(v, d, r, c);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_busy || m_fifo > 0) && guard < 300) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", 64'((m_busy || m_fifo > 0) ? 1 : 0), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [TW-1:0] rnd_rec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: checks every handshake against the scoreboard and status against the model.
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat  = '0;
    logic [32:0] e;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tvalid", 64'(m_axis_tvalid), 64'(m_busy));
            chk("fill_level", 64'(fill_level_o), 64'(m_fifo));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
            chk("drop_count", 64'(drop_count_o), 64'(m_drops));
            if (prev_stall) begin
                chk("stall_tdata", 64'(m_axis_tdata), 64'(prev_beat[31:0]));
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_beat[32]));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", m_axis_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", 64'(m_axis_tdata), 64'(e[31:0]));
                    chk("tlast", 64'(m_axis_tlast), 64'(e[32]));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [TW-1:0] rec;
    logic [TW-1:0] rec1;

    initial begin
        rec1 = 128'h44444444_33333333_22222222_11111111;

        @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_fill", 64'(fill_level_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_drops", 64'(drop_count_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single record, latency and beat order
        cyc(1'b1, rec1, 1'b1, 1'b0);
        chk("t1_tvalid_edgeN", 64'(m_axis_tvalid), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t1_tvalid_edgeN1", 64'(m_axis_tvalid), 64'd1);
        chk("t1_first_beat", 64'(m_axis_tdata), 64'h11111111);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t1_tvalid_after", 64'(m_axis_tvalid), 64'd0);
        drain();

        // 2: backpressure pattern 1,0,0,1,...
        cyc(1'b1, rnd_rec(), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc(1'b0, '0, (i % 3 == 0) ? 1'b1 : 1'b0, 1'b0);
        drain();

        // 3: overflow with tready low, then back-to-back drain
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, rnd_rec(), 1'b0, 1'b0);
        chk("t3_fill", 64'(fill_level_o), 64'd4);
        chk("t3_overflow", 64'(overflow_o), 64'd1);
        chk("t3_drops", 64'(drop_count_o), 64'd1);
        repeat (21) cyc(1'b0, '0, 1'b1, 1'b0);
        drain();

        // 4: full FIFO, push dropped while the last beat pops the head
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, rnd_rec(), 1'b0, 1'b0);
        chk("t4_fill_full", 64'(fill_level_o), 64'd4);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, rnd_rec(), 1'b1, 1'b0);
        chk("t4_fill_after", 64'(fill_level_o), 64'd3);
        chk("t4_drops", 64'(drop_count_o), 64'd1);

        // 5: clear alone, clear with drop, saturation
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t5_clr_overflow", 64'(overflow_o), 64'd0);
        chk("t5_clr_drops", 64'(drop_count_o), 64'd0);
        cyc(1'b1, rnd_rec(), 1'b0, 1'b0);
        cyc(1'b1, rnd_rec(), 1'b0, 1'b1);
        chk("t5_clrdrop_overflow", 64'(overflow_o), 64'd1);
        chk("t5_clrdrop_drops", 64'(drop_count_o), 64'd1);
        repeat (20) cyc(1'b1, rnd_rec(), 1'b0, 1'b0);
        chk("t5_saturate", 64'(drop_count_o), 64'(MAXC));
        drain();

        // 6: async reset during beat 2
        cyc(1'b1, rnd_rec(), 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_tdata", 64'(m_axis_tdata), 64'd0);
        chk("t6_tlast", 64'(m_axis_tlast), 64'd0);
        chk("t6_fill", 64'(fill_level_o), 64'd0);
        chk("t6_overflow", 64'(overflow_o), 64'd0);
        chk("t6_drops", 64'(drop_count_o), 64'd0);
        m_fifo = 0; m_busy = 1'b0; m_left = 0; m_ovf = 1'b0; m_drops = 0;
        exp_q.delete();
        trace_valid_i = 1'b0;
        clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, rnd_rec(), 1'b1, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rec = rnd_rec();
            cyc(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, rec,
                ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
